// File: rtl/repetition_detector_ctrl_pkg.sv
// repetition_detector_ctrl_pkg: FSM state encoding and the total-beat width helper shared by the controller
package repetition_detector_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONFIG = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
  function automatic int beat_w(input int log_iters, input int log_reads);
    return log_iters + log_reads;
  endfunction
endpackage

// File: rtl/repetition_detector_ctrl_desc_queue.sv
// rd_desc_queue: DEPTH-entry descriptor FIFO (clk, async rst, push/wdata in, pop/rdata out, full/empty flags)
module rd_desc_queue #(
  parameter int W         = 32,
  parameter int DEPTH     = 2,
  parameter int LOG_DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]         mem [DEPTH];
  logic [LOG_DEPTH-1:0] wp, rp;
  logic [LOG_DEPTH:0]   cnt;
  logic                 do_push, do_pop;
  assign full    = cnt == (LOG_DEPTH+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= do_push ? wp + LOG_DEPTH'(1) : wp;
      rp  <= do_pop ? rp + LOG_DEPTH'(1) : rp;
      cnt <= (do_push & ~do_pop) ? cnt + (LOG_DEPTH+1)'(1) :
             (do_pop & ~do_push) ? cnt - (LOG_DEPTH+1)'(1) : cnt;
    end
  end
endmodule

// File: rtl/repetition_detector_ctrl.sv
// repetition_detector_ctrl: layer sequencer (desc_* queue in, configure/num_* to detector, mon_* beats in, busy/done/zero_groups/err status out)
module repetition_detector_ctrl
  import repetition_detector_ctrl_pkg::*;
#(
  parameter int GROUP_SIZE             = 4,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16,
  parameter int DESC_DEPTH             = 2,
  parameter int LOG_DESC_DEPTH         = 1,
  parameter int CNT_W                  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LOG_MAX_ITERS-1:0]          desc_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] desc_reads,
  input  logic                              desc_valid,
  output logic                              desc_avail,
  output logic                              configure,
  output logic [LOG_MAX_ITERS-1:0]          num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic                              mon_valid,
  input  logic [GROUP_SIZE-1:0]             mon_zero_info,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_W-1:0]                  zero_groups,
  output logic                              err
);
  localparam int BEAT_W = beat_w(LOG_MAX_ITERS, LOG_MAX_READS_PER_ITER);
  state_t                            state, state_nxt;
  logic                              q_full, q_empty, pop, head_ok, load, beat, last;
  logic [BEAT_W-1:0]                 q_head, beats_left;
  logic [LOG_MAX_ITERS-1:0]          head_iters;
  logic [LOG_MAX_READS_PER_ITER-1:0] head_reads;
  assign desc_avail = ~q_full;
  assign {head_iters, head_reads} = q_head;
  rd_desc_queue #(
    .W(BEAT_W),
    .DEPTH(DESC_DEPTH),
    .LOG_DEPTH(LOG_DESC_DEPTH)
  ) u_queue (
    .clk(clk),
    .rst(rst),
    .push(desc_valid & ~q_full),
    .wdata({desc_iters, desc_reads}),
    .pop(pop),
    .rdata(q_head),
    .full(q_full),
    .empty(q_empty)
  );
  always_comb begin
    head_ok   = (head_iters != '0) && (head_reads != '0);
    pop       = (state == ST_IDLE) && !q_empty;
    load      = pop && head_ok;
    beat      = (state == ST_RUN) && mon_valid;
    last      = beat && (beats_left == BEAT_W'(1));
    configure = state == ST_CONFIG;
    busy      = (state == ST_CONFIG) || (state == ST_RUN);
    done      = state == ST_DONE;
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = load ? ST_CONFIG : ST_IDLE;
      ST_CONFIG: state_nxt = ST_RUN;
      ST_RUN:    state_nxt = last ? ST_DONE : ST_RUN;
      default:   state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_iters          <= '0;
      num_reads_per_iter <= '0;
      beats_left         <= '0;
      zero_groups        <= '0;
      err                <= 1'b0;
    end else begin
      err <= (mon_valid && state != ST_RUN) || (pop && !head_ok) || (err && !load);
      if (load) begin
        num_iters          <= head_iters;
        num_reads_per_iter <= head_reads;
        beats_left         <= BEAT_W'(head_iters) * BEAT_W'(head_reads);
        zero_groups        <= '0;
      end else if (beat) begin
        beats_left  <= beats_left - BEAT_W'(1);
        zero_groups <= (&mon_zero_info && !(&zero_groups)) ? zero_groups + CNT_W'(1) : zero_groups;
      end
    end
  end
endmodule

// File: tb/tb_repetition_detector_ctrl.sv
// tb_repetition_detector_ctrl: scoreboard bench for the layer sequencer
module tb_repetition_detector_ctrl;
  typedef struct {
    logic [15:0] it;
    logic [15:0] rd;
  } cfg_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] desc_iters = '0, desc_reads = '0;
  logic        desc_valid = 1'b0, mon_valid = 1'b0;
  logic [3:0]  mon_zero_info = '0;
  logic        desc_avail, configure, busy, done, err;
  logic [15:0] num_iters, num_reads;
  logic [31:0] zero_groups;
  logic [15:0] s_desc_iters = '0, s_desc_reads = '0;
  logic        s_desc_valid = 1'b0, s_mon_valid = 1'b0;
  logic [3:0]  s_mon_zero_info = '0;
  logic        s_desc_avail, s_configure, s_busy, s_done, s_err;
  logic [15:0] s_num_iters, s_num_reads;
  logic [3:0]  s_zero_groups;
  int          n_cmp = 0, n_bad = 0, n_cfg = 0, n_done = 0;
  cfg_t        cfg_q[$];
  logic [31:0] done_q[$];
  always #5 clk = ~clk;
  repetition_detector_ctrl dut (
    .clk(clk), .rst(rst), .desc_iters(desc_iters), .desc_reads(desc_reads), .desc_valid(desc_valid),
    .desc_avail(desc_avail), .configure(configure), .num_iters(num_iters), .num_reads_per_iter(num_reads),
    .mon_valid(mon_valid), .mon_zero_info(mon_zero_info), .busy(busy), .done(done),
    .zero_groups(zero_groups), .err(err)
  );
  repetition_detector_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .desc_iters(s_desc_iters), .desc_reads(s_desc_reads), .desc_valid(s_desc_valid),
    .desc_avail(s_desc_avail), .configure(s_configure), .num_iters(s_num_iters), .num_reads_per_iter(s_num_reads),
    .mon_valid(s_mon_valid), .mon_zero_info(s_mon_zero_info), .busy(s_busy), .done(s_done),
    .zero_groups(s_zero_groups), .err(s_err)
  );
  task automatic cycle();
    cfg_t e;
    logic [31:0] z;
    @(posedge clk);
    #1;
    if (configure) begin
      n_cfg++;
      n_cmp++;
      if (cfg_q.size() == 0) begin
        n_bad++;
        $display("FAIL cfg_unexpected: got configure iters=%0d reads=%0d, required no configure", num_iters, num_reads);
      end else begin
        e = cfg_q.pop_front();
        if ({num_iters, num_reads} !== {e.it, e.rd}) begin
          n_bad++;
          $display("FAIL cfg_values: got iters=%0d reads=%0d, required iters=%0d reads=%0d", num_iters, num_reads, e.it, e.rd);
        end
      end
    end
    if (done) begin
      n_done++;
      n_cmp++;
      if (done_q.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected: got done zero_groups=%0d, required no done", zero_groups);
      end else begin
        z = done_q.pop_front();
        if (zero_groups !== z) begin
          n_bad++;
          $display("FAIL done_zero_groups: got %0d, required %0d", zero_groups, z);
        end
      end
    end
  endtask
  task automatic push_desc(input logic [15:0] it, input logic [15:0] rd, input bit ok, input logic [31:0] zg);
    cfg_t e;
    desc_valid = 1'b1;
    desc_iters = it;
    desc_reads = rd;
    if (desc_avail && ok) begin
      e.it = it;
      e.rd = rd;
      cfg_q.push_back(e);
      done_q.push_back(zg);
    end
    cycle();
    desc_valid = 1'b0;
  endtask
  task automatic wait_run(input string tag);
    int k = 0;
    while (!(busy && !configure) && k < 20) begin
      cycle();
      k++;
    end
    n_cmp++;
    if (!(busy && !configure)) begin
      n_bad++;
      $display("FAIL %s_run_timeout: got busy=%b configure=%b, required RUN within 20 cycles", tag, busy, configure);
    end
  endtask
  task automatic beats(input int n, input int mask);
    for (int i = 0; i < n; i++) begin
      mon_valid = 1'b1;
      mon_zero_info = ((mask >> i) & 1) != 0 ? 4'hF : 4'(i % 15);
      cycle();
    end
    mon_valid = 1'b0;
    mon_zero_info = '0;
  endtask
  task automatic test_reset();
    #12;
    n_cmp++;
    if ({busy, configure, done, err, num_iters, num_reads, zero_groups} !== '0 || desc_avail !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b cfg=%b done=%b err=%b it=%0d rd=%0d zg=%0d avail=%b, required all 0 avail=1",
               busy, configure, done, err, num_iters, num_reads, zero_groups, desc_avail);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_single();
    int c0 = n_cfg, d0 = n_done;
    push_desc(16'd2, 16'd3, 1'b1, 32'd2);
    wait_run("single");
    beats(6, 18);
    n_cmp++;
    if (n_done !== d0 + 1 || n_cfg !== c0 + 1) begin
      n_bad++;
      $display("FAIL single_counts: got done=%0d configure=%0d at last beat, required 1 and 1", n_done - d0, n_cfg - c0);
    end
    cycle();
    n_cmp++;
    if (done !== 1'b0 || zero_groups !== 32'd2 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after: got done=%b zg=%0d err=%b, required done=0 zg=2 err=0", done, zero_groups, err);
    end
  endtask
  task automatic test_back_to_back();
    int it[3] = '{1, 2, 1};
    int rd[3] = '{2, 1, 1};
    int zg[3] = '{0, 2, 1};
    int mk[3] = '{0, 3, 1};
    int k = 0, guard = 0, d0 = n_done;
    bit acc;
    cfg_t e;
    while (k < 3 && guard < 10) begin
      desc_valid = 1'b1;
      desc_iters = 16'(it[k]);
      desc_reads = 16'(rd[k]);
      acc = desc_avail;
      if (acc) begin
        e.it = 16'(it[k]);
        e.rd = 16'(rd[k]);
        cfg_q.push_back(e);
        done_q.push_back(32'(zg[k]));
      end
      cycle();
      if (acc) k++;
      guard++;
    end
    desc_valid = 1'b0;
    n_cmp++;
    if (k !== 3 || desc_avail !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_full: got accepted=%0d desc_avail=%b, required 3 and 0", k, desc_avail);
    end
    for (int j = 0; j < 3; j++) begin
      wait_run("b2b");
      beats(it[j] * rd[j], mk[j]);
    end
    n_cmp++;
    if (n_done !== d0 + 3 || desc_avail !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_done: got %0d done pulses avail=%b, required 3 and 1", n_done - d0, desc_avail);
    end
  endtask
  task automatic test_invalid();
    int c0 = n_cfg, d0 = n_done;
    push_desc(16'd0, 16'd5, 1'b0, 32'd0);
    push_desc(16'd1, 16'd1, 1'b1, 32'd0);
    n_cmp++;
    if (err !== 1'b1 || configure !== 1'b0) begin
      n_bad++;
      $display("FAIL invalid_drop: got err=%b configure=%b, required err=1 configure=0", err, configure);
    end
    cycle();
    n_cmp++;
    if (err !== 1'b0 || configure !== 1'b1) begin
      n_bad++;
      $display("FAIL invalid_next: got err=%b configure=%b, required err=0 configure=1", err, configure);
    end
    wait_run("invalid");
    beats(1, 0);
    n_cmp++;
    if (n_done !== d0 + 1 || n_cfg !== c0 + 1) begin
      n_bad++;
      $display("FAIL invalid_counts: got done=%0d configure=%0d, required 1 and 1", n_done - d0, n_cfg - c0);
    end
  endtask
  task automatic test_spurious();
    cycle();
    mon_valid = 1'b1;
    mon_zero_info = 4'hF;
    cycle();
    mon_valid = 1'b0;
    mon_zero_info = '0;
    n_cmp++;
    if (err !== 1'b1 || zero_groups !== 32'd0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious: got err=%b zg=%0d busy=%b, required err=1 zg=0 busy=0", err, zero_groups, busy);
    end
    cycle();
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL spurious_sticky: got err=%b, required 1", err);
    end
  endtask
  task automatic test_async_reset();
    int d0;
    push_desc(16'd1, 16'd6, 1'b1, 32'd0);
    wait_run("rst");
    beats(2, 3);
    n_cmp++;
    if (zero_groups !== 32'd2 || busy !== 1'b1 || dut.beats_left !== 32'd4) begin
      n_bad++;
      $display("FAIL rst_pre: got zg=%0d busy=%b beats_left=%0d, required 2 1 4", zero_groups, busy, dut.beats_left);
    end
    #2;
    rst = 1'b1;
    #1;
    done_q.delete();
    n_cmp++;
    if ({busy, configure, done, err, num_iters, num_reads, zero_groups} !== '0 || desc_avail !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_async: got busy=%b cfg=%b done=%b err=%b it=%0d rd=%0d zg=%0d avail=%b, required all 0 avail=1",
               busy, configure, done, err, num_iters, num_reads, zero_groups, desc_avail);
    end
    @(negedge clk);
    rst = 1'b0;
    d0 = n_done;
    push_desc(16'd1, 16'd1, 1'b1, 32'd1);
    wait_run("rst_after");
    beats(1, 1);
    n_cmp++;
    if (n_done !== d0 + 1) begin
      n_bad++;
      $display("FAIL rst_after: got %0d done pulses, required 1", n_done - d0);
    end
  endtask
  task automatic test_wide();
    logic [63:0] p = 64'd65535 * 64'd65535;
    push_desc(16'hFFFF, 16'hFFFF, 1'b1, 32'd0);
    wait_run("wide");
    n_cmp++;
    if (dut.beats_left !== p[31:0] || p[63:32] !== 32'd0) begin
      n_bad++;
      $display("FAIL wide_product: got beats_left=%h, required %h", dut.beats_left, p[31:0]);
    end
    beats(3, 7);
    n_cmp++;
    if (dut.beats_left !== p[31:0] - 32'd3 || zero_groups !== 32'd3 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL wide_count: got beats_left=%h zg=%0d done=%b, required %h 3 0", dut.beats_left, zero_groups, done, p[31:0] - 32'd3);
    end
    #2;
    rst = 1'b1;
    done_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_saturate();
    int k = 0;
    int seen = 0;
    s_desc_valid = 1'b1;
    s_desc_iters = 16'd1;
    s_desc_reads = 16'd20;
    cycle();
    s_desc_valid = 1'b0;
    while (!(s_busy && !s_configure) && k < 20) begin
      cycle();
      k++;
    end
    for (int i = 0; i < 20; i++) begin
      s_mon_valid = 1'b1;
      s_mon_zero_info = 4'hF;
      cycle();
      if (s_done) seen = i + 1;
      if (i == 14) begin
        n_cmp++;
        if (s_zero_groups !== 4'd15) begin
          n_bad++;
          $display("FAIL sat_reach: got zg=%0d after 15 beats, required 15", s_zero_groups);
        end
      end
    end
    s_mon_valid = 1'b0;
    n_cmp++;
    if (seen !== 20 || s_zero_groups !== 4'd15 || s_err !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_final: got done_at=%0d zg=%0d err=%b, required 20 15 0", seen, s_zero_groups, s_err);
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid();
    test_spurious();
    test_async_reset();
    test_wide();
    test_saturate();
    repeat (3) cycle();
    n_cmp++;
    if (cfg_q.size() != 0 || done_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d configures and %0d dones outstanding, required 0 and 0", cfg_q.size(), done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/repetition_detector_ctrl.md
Name: repetition_detector_ctrl

Overview:
Layer-level sequencer for the repetition detector. Queues layer descriptors (iterations × reads per iteration) and drives the detector's one-cycle configure interface. It then tracks completion by counting output beats observed on the detector's valid_out. While a layer runs, it also counts all-zero activation groups using the detector's zero_info field, and reports done, busy and error status to the top-level control.

Parameters:
GROUP_SIZE, 4, activations per group; width of the monitored zero_info field
LOG_MAX_ITERS, 16, width of the iteration count
LOG_MAX_READS_PER_ITER, 16, width of the reads-per-iteration count
DESC_DEPTH, 2, descriptor queue slots (power of two, ≥2)
LOG_DESC_DEPTH, 1, log2(DESC_DEPTH)
CNT_W, 32, width of the zero-group statistics counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
desc_iters  in  LOG_MAX_ITERS  descriptor: number of iterations
desc_reads  in  LOG_MAX_READS_PER_ITER  descriptor: reads per iteration
desc_valid  in  1  descriptor valid
desc_avail  out  1  descriptor queue can accept this cycle
configure  out  1  one-cycle configure pulse to the detector
num_iters  out  LOG_MAX_ITERS  configured iterations (held stable)
num_reads_per_iter  out  LOG_MAX_READS_PER_ITER  configured reads per iteration (held stable)
mon_valid  in  1  detector valid_out (one beat per cycle high)
mon_zero_info  in  GROUP_SIZE  detector zero_info bits (data_out upper field)
busy  out  1  layer in CONFIG or RUN
done  out  1  one-cycle pulse when the layer's last beat is observed
zero_groups  out  CNT_W  all-zero groups counted in the current or last layer
err  out  1  sticky protocol error flag

Behaviour:
- Reset (asynchronous, rst=1): all outputs are 0, the queue is emptied, the FSM goes to IDLE, and pending descriptors are lost. Deasserting reset mid-layer leaves the controller in IDLE. The detector must be reset together with this block.
- Descriptor queue:
  - A push occurs when desc_valid & desc_avail; desc_avail = ~queue_full.
  - A push and a pop in the same cycle are allowed.
  - desc_valid while ~desc_avail: the descriptor is ignored and no error is raised.
- Descriptor screening: a descriptor with desc_iters==0 or desc_reads==0 is still pushed. On pop it is discarded, err is set, and no configure is issued.
- FSM IDLE → CONFIG → RUN → DONE → IDLE.
  - IDLE, queue non-empty and head valid: pop the head.
    - Register num_iters and num_reads_per_iter.
    - Compute beats_left = iters*reads, width LOG_MAX_ITERS+LOG_MAX_READS_PER_ITER, unsigned, no overflow.
    - Clear zero_groups; go to CONFIG.
  - IDLE, queue non-empty and head invalid: pop and drop it, set err, stay in IDLE.
  - CONFIG: configure=1 for exactly this cycle; num_iters and num_reads_per_iter stay driven from then until the next pop. Next state RUN.
  - RUN: each cycle with mon_valid=1:
    - decrement beats_left;
    - if mon_zero_info is all ones, increment zero_groups, saturating at 2^CNT_W-1.
    - When mon_valid arrives with beats_left==1, go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE. The next descriptor can be popped on the following cycle, so the minimum gap from done to the next configure is 2 cycles.
- busy = (state==CONFIG)|(state==RUN).
- mon_valid in IDLE, CONFIG or DONE is a spurious beat: set err and ignore the beat (no count, no statistics).
- err is sticky; it clears only on reset or when a valid descriptor is popped.
- zero_groups holds its final value after DONE until the next valid pop.
- Latency: descriptor accepted at edge N → configure high in cycle N+2 (queue register plus the IDLE pop). The earliest detector beat is cycle N+3. done rises 1 cycle after the edge that samples the last beat.

Decomposition:
- Shared package / header (RTLinf.vh):
  - FSM state encoding: ST_IDLE=0, ST_CONFIG=1, ST_RUN=2, ST_DONE=3;
  - total-beat width constant (LOG_MAX_ITERS+LOG_MAX_READS_PER_ITER).
- One sub-module: rd_desc_queue, a DESC_DEPTH-entry FIFO of {iters, reads} with full/empty flags and async active-high reset. The existing FIFO block is not reused because of its reset style.

Test Plan:
- Push iters=2, reads=3; drive mon_valid for 6 cycles with mon_zero_info=4'b1111 on beats 2 and 5 → exactly one configure with num_iters=2 and num_reads_per_iter=3; done 1 cycle after beat 6; zero_groups=2; err=0.
- Push 3 descriptors back-to-back with desc_valid held → desc_avail drops after 2 are queued; the third is accepted once the first pops; the three layers run in order with three done pulses.
- Push iters=0, reads=5, then iters=1, reads=1 → first is dropped with err=1 and no configure; second configures, err clears at its pop, one beat → done.
- mon_valid=1 while IDLE → err=1; zero_groups and state unchanged.
- Assert rst during RUN with beats_left=4 → all outputs 0 immediately (asynchronously), queue empty; a new descriptor after release runs normally.
- iters=65535, reads=65535 with constant mon_valid → done after 4294836225 beats (shortened in simulation by forcing beats_left, checking the width); zero_groups saturates when CNT_W=4 and all zero_info bits are 1.
